// File: rtl/shared_reg_write_arbiter_pkg.sv
// Shared types for the shared-register write arbiter.
// The FSM state encoding and the index-width helper live here.
package shared_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Width of a requester index; a single-requester build still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_rr_priority_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N_REQ.
// Purely combinational; the caller registers the result.
module rr_priority_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Rotate so that requester ptr sits at bit 0, then take the lowest set bit.
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        valid  = |req;
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin arbiter driving one CE-gated register: IDLE -> WRITE -> ACK, 3 cycles per write.
// All outputs registered; requesters hold req/data until their ack pulse.
module shared_reg_write_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 12,
    parameter int CNT_W = 16,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       reg_data,
    output logic                   reg_ce,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic [CNT_W-1:0]       write_count
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_dat;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_vld),
        .winner (pick_idx)
    );

    always_comb begin
        pick_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_dat = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            ack         <= '0;
            reg_ce      <= 1'b0;
            reg_data    <= '0;
            grant_idx   <= '0;
            ptr         <= '0;
            write_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (pick_vld) begin
                        state     <= WRITE;
                        reg_ce    <= 1'b1;
                        reg_data  <= pick_dat;
                        grant_idx <= pick_idx;
                    end else begin
                        reg_ce <= 1'b0;
                    end
                end
                WRITE: begin
                    state       <= ACK;
                    reg_ce      <= 1'b0;
                    ack         <= N_REQ'(1) << grant_idx;
                    ptr         <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    write_count <= write_count + CNT_W'(1);
                end
                ACK: begin
                    state <= IDLE;
                    ack   <= '0;
                end
                default: begin
                    state  <= IDLE;
                    ack    <= '0;
                    reg_ce <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// Directed bench for shared_reg_write_arbiter with a behavioural copy of the shared register.
module tb_shared_reg_write_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 12;
    localparam int CNT_W = 2;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       reg_data;
    logic                   reg_ce;
    logic [1:0]             grant_idx;
    logic                   busy;
    logic [CNT_W-1:0]       write_count;
    logic [WIDTH-1:0]       reg_q;

    int checks   = 0;
    int failures = 0;

    shared_reg_write_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .reg_data    (reg_data),
        .reg_ce      (reg_ce),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 CLK = ~CLK;

    // The shared register, cleared by the same reset.
    always_ff @(posedge CLK) begin
        if (RESET)       reg_q <= '0;
        else if (reg_ce) reg_q <= reg_data;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [WIDTH-1:0] data_exp, input logic [CNT_W-1:0] cnt_exp);
        chk({tag, "_ce"},   32'(reg_ce), 32'd0);
        chk({tag, "_ack"},  32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_data"}, 32'(reg_data), 32'(data_exp));
        chk({tag, "_cnt"},  32'(write_count), 32'(cnt_exp));
    endtask

    // Edge after the IDLE decision: expect a one-cycle CE with the winner's word.
    task automatic chk_write(input string tag, input int w, input logic [WIDTH-1:0] d);
        chk({tag, "_ce"},    32'(reg_ce), 32'd1);
        chk({tag, "_grant"}, 32'(grant_idx), 32'(w));
        chk({tag, "_data"},  32'(reg_data), 32'(d));
        chk({tag, "_busy"},  32'(busy), 32'd1);
        chk({tag, "_noack"}, 32'(ack), 32'd0);
    endtask

    task automatic chk_ack(input string tag, input int w, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c);
        chk({tag, "_ack"}, 32'(ack), 32'(1) << w);
        chk({tag, "_ce"},  32'(reg_ce), 32'd0);
        chk({tag, "_cnt"}, 32'(write_count), 32'(c));
        chk({tag, "_reg"}, 32'(reg_q), 32'(d));
    endtask

    initial begin
        RESET    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (3) tick();
        chk_idle("rst0", 12'h000, 2'd0);
        chk("rst0_grant", 32'(grant_idx), 32'd0);
        chk("rst0_reg", 32'(reg_q), 32'd0);

        // Single request from requester 1.
        RESET = 1'b0;
        req   = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 12'hABC;
        tick();
        chk_write("single_wr", 1, 12'hABC);
        tick();
        chk_ack("single_ack", 1, 12'hABC, 2'd1);
        req = 4'b0000;
        tick();
        chk_idle("single_end", 12'hABC, 2'd1);
        tick();
        chk_idle("single_hold", 12'hABC, 2'd1);

        // ptr=2, req 0 and 1: scan wraps to 0; requester 3 arrives late.
        req = 4'b0011;
        req_data[0*WIDTH +: WIDTH] = 12'h111;
        req_data[1*WIDTH +: WIDTH] = 12'h222;
        tick();
        chk_write("wrap_w0", 0, 12'h111);
        tick();
        chk_ack("wrap_a0", 0, 12'h111, 2'd2);
        req = 4'b1010;
        req_data[3*WIDTH +: WIDTH] = 12'h333;
        tick();
        chk("wrap_gap0", 32'(ack), 32'd0);
        tick();
        chk_write("wrap_w1", 1, 12'h222);
        tick();
        chk_ack("wrap_a1", 1, 12'h222, 2'd3);
        req = 4'b1000;
        tick();
        tick();
        chk_write("wrap_w3", 3, 12'h333);
        tick();
        chk_ack("wrap_a3", 3, 12'h333, 2'd0);
        req = 4'b0000;
        tick();

        // All four continuously requesting from ptr=0: acks 0,1,2,3 every 3 cycles.
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = 12'hA00 + 12'(i);
        for (int i = 0; i < N_REQ; i++) begin
            tick();
            chk_write($sformatf("rr%0d_wr", i), i, 12'hA00 + 12'(i));
            tick();
            chk_ack($sformatf("rr%0d_ack", i), i, 12'hA00 + 12'(i), 2'(i + 1));
            req[i] = 1'b0;
            tick();
            chk($sformatf("rr%0d_gap", i), 32'(ack), 32'd0);
        end
        tick();
        chk_idle("rr_end", 12'hA03, 2'd0);

        // Request withdrawn during WRITE still completes and acks.
        req = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 12'h777;
        tick();
        chk_write("drop_wr", 2, 12'h777);
        req = 4'b0000;
        tick();
        chk_ack("drop_ack", 2, 12'h777, 2'd1);
        tick();
        chk_idle("drop_end", 12'h777, 2'd1);
        tick();
        chk_idle("drop_idle", 12'h777, 2'd1);

        // Reset landing in the WRITE cycle: no late CE, no ack, register cleared.
        req = 4'b0001;
        req_data[0*WIDTH +: WIDTH] = 12'h5A5;
        tick();
        chk_write("rstw_wr", 0, 12'h5A5);
        RESET = 1'b1;
        req   = 4'b0000;
        tick();
        chk_idle("rstw_1", 12'h000, 2'd0);
        chk("rstw_grant", 32'(grant_idx), 32'd0);
        chk("rstw_reg", 32'(reg_q), 32'd0);
        tick();
        tick();
        chk_idle("rstw_3", 12'h000, 2'd0);
        RESET = 1'b0;
        tick();
        chk_idle("rstw_rel", 12'h000, 2'd0);
        chk("rstw_reg_hold", 32'(reg_q), 32'd0);

        // ptr restarted at 0 after reset: requesters 1 and 3 -> 1 wins.
        req = 4'b1010;
        req_data[1*WIDTH +: WIDTH] = 12'h0F1;
        req_data[3*WIDTH +: WIDTH] = 12'h0F3;
        tick();
        chk_write("post_wr", 1, 12'h0F1);
        tick();
        chk_ack("post_ack", 1, 12'h0F1, 2'd1);
        req = 4'b0000;
        tick();
        tick();
        chk_idle("post_idle", 12'h0F1, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
